fetch_decode_buffer: RTL and testbench

- Decode-side receiver of the 64-bit fetch packet; acts as the IF/ID pipeline register.
- Packet layout: [63:48] is the 16-bit sideband passthrough, [47:32]… no split; [47:16] is the 32-bit PC+1, [15:0] is the instruction word.
- Handles stall (hold), flush (inject NOP) and two-word instructions, where a 16-bit immediate arrives in the following fetch word.
- Presents one assembled, validated instruction per cycle to the decode stage.

---
 rtl/fetch_decode_buffer.sv | 169 ++++++++++++++++
 tb/tb_fetch_decode_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_buffer.sv
// ---------------------------------------------------------------------------
// fetch_decode_buffer
//
// IF/ID pipeline register on the decode side. It receives 64-bit fetch packets
// {sideband[15:0], pc_plus[31:0], instr[15:0]} and presents one complete
// instruction per cycle to decode. A first word with In[IMM_FLAG_BIT]=1 is
// held in pending registers until its 16-bit immediate arrives in the next
// fetch word. While that first word waits, the output shows a NOP bubble.
//
// Optional build macro: FDB_STALL_COUNT_EN adds a saturating Stall_Count port.
//
// Ports:
//   Clk         clock; all state updates on the rising edge
//   Rst         asynchronous active-high reset
//   In          fetch packet {sideband, pc_plus, instr}
//   Stall       hold every register (pending registers included)
//   Flush       discard buffered content and the current word; wins over Stall
//   Out_Instr   first instruction word (NOP_WORD on reset, flush or bubble)
//   Out_Imm     zero-extended immediate word (0 for one-word instructions)
//   Out_PC      pc_plus captured with the first word
//   Out_Side    sideband captured with the first word
//   Out_Valid   Out_* hold a complete instruction
//   Fetch_Hold  combinational; high while waiting for an immediate word
//   Stall_Count (FDB_STALL_COUNT_EN only) saturating count of stall cycles
// ---------------------------------------------------------------------------
module fetch_decode_buffer #(
    parameter int          IMM_FLAG_BIT = 15,
    parameter logic [15:0] NOP_WORD     = 16'h0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [63:0] In,
    input  logic        Stall,
    input  logic        Flush,
    output logic [15:0] Out_Instr,
    output logic [31:0] Out_Imm,
    output logic [31:0] Out_PC,
    output logic [15:0] Out_Side,
    output logic        Out_Valid,
    output logic        Fetch_Hold
`ifdef FDB_STALL_COUNT_EN
    ,
    output logic [15:0] Stall_Count
`endif
);

    typedef enum logic {S_FIRST = 1'b0, S_IMM = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [15:0] pend_instr_reg, pend_instr_next;
    logic [31:0] pend_pc_reg, pend_pc_next;
    logic [15:0] pend_side_reg, pend_side_next;
    logic [15:0] instr_reg, instr_next;
    logic [31:0] imm_reg, imm_next;
    logic [31:0] pc_reg, pc_next;
    logic [15:0] side_reg, side_next;
    logic        valid_reg, valid_next;

    wire [15:0] in_side  = In[63:48];
    wire [31:0] in_pc    = In[47:16];
    wire [15:0] in_instr = In[15:0];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg      <= S_FIRST;
            pend_instr_reg <= 16'h0000;
            pend_pc_reg    <= 32'h0;
            pend_side_reg  <= 16'h0000;
            instr_reg      <= NOP_WORD;
            imm_reg        <= 32'h0;
            pc_reg         <= 32'h0;
            side_reg       <= 16'h0000;
            valid_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pend_instr_reg <= pend_instr_next;
            pend_pc_reg    <= pend_pc_next;
            pend_side_reg  <= pend_side_next;
            instr_reg      <= instr_next;
            imm_reg        <= imm_next;
            pc_reg         <= pc_next;
            side_reg       <= side_next;
            valid_reg      <= valid_next;
        end
    end

    always_comb begin
        // Default: hold everything (this is also the stall behaviour).
        state_next      = state_reg;
        pend_instr_next = pend_instr_reg;
        pend_pc_next    = pend_pc_reg;
        pend_side_next  = pend_side_reg;
        instr_next      = instr_reg;
        imm_next        = imm_reg;
        pc_next         = pc_reg;
        side_next       = side_reg;
        valid_next      = valid_reg;

        if (Flush) begin
            state_next      = S_FIRST;
            pend_instr_next = 16'h0000;
            pend_pc_next    = 32'h0;
            pend_side_next  = 16'h0000;
            instr_next      = NOP_WORD;
            imm_next        = 32'h0;
            pc_next         = 32'h0;
            side_next       = 16'h0000;
            valid_next      = 1'b0;
        end else if (!Stall) begin
            case (state_reg)
                S_FIRST: begin
                    if (In[IMM_FLAG_BIT]) begin
                        // First half of a two-word instruction: park it and
                        // show a bubble until the immediate arrives.
                        pend_instr_next = in_instr;
                        pend_pc_next    = in_pc;
                        pend_side_next  = in_side;
                        instr_next      = NOP_WORD;
                        imm_next        = 32'h0;
                        pc_next         = 32'h0;
                        side_next       = 16'h0000;
                        valid_next      = 1'b0;
                        state_next      = S_IMM;
                    end else begin
                        instr_next = in_instr;
                        imm_next   = 32'h0;
                        pc_next    = in_pc;
                        side_next  = in_side;
                        valid_next = 1'b1;
                    end
                end
                S_IMM: begin
                    // The whole 16-bit word is immediate data, flag bit included.
                    instr_next = pend_instr_reg;
                    imm_next   = {16'h0000, in_instr};
                    pc_next    = pend_pc_reg;
                    side_next  = pend_side_reg;
                    valid_next = 1'b1;
                    state_next = S_FIRST;
                end
                default: state_next = S_FIRST;
            endcase
        end
    end

    assign Out_Instr  = instr_reg;
    assign Out_Imm    = imm_reg;
    assign Out_PC     = pc_reg;
    assign Out_Side   = side_reg;
    assign Out_Valid  = valid_reg;
    assign Fetch_Hold = (state_reg == S_IMM);

`ifdef FDB_STALL_COUNT_EN
    logic [15:0] stall_count_reg;

    // Counts only genuine stall cycles; a flush cycle does not count and does
    // not clear the counter.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_count_reg <= 16'h0000;
        end else if (Stall && !Flush && (stall_count_reg != 16'hFFFF)) begin
            stall_count_reg <= stall_count_reg + 16'h0001;
        end
    end

    assign Stall_Count = stall_count_reg;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_buffer
//
// Directed stimulus for fetch_decode_buffer. A packet-level model (a queue of
// waiting first-word packets plus the expected output record) is advanced on
// every rising edge; a negedge process compares the DUT against it. Literal
// expectations along the directed sequence pin the model itself.
// ---------------------------------------------------------------------------
module tb_fetch_decode_buffer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [63:0] In = 64'h0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic [15:0] Out_Instr;
    logic [31:0] Out_Imm;
    logic [31:0] Out_PC;
    logic [15:0] Out_Side;
    logic        Out_Valid;
    logic        Fetch_Hold;
`ifdef FDB_STALL_COUNT_EN
    logic [15:0] Stall_Count;
`endif

    fetch_decode_buffer dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .In         (In),
        .Stall      (Stall),
        .Flush      (Flush),
        .Out_Instr  (Out_Instr),
        .Out_Imm    (Out_Imm),
        .Out_PC     (Out_PC),
        .Out_Side   (Out_Side),
        .Out_Valid  (Out_Valid),
        .Fetch_Hold (Fetch_Hold)
`ifdef FDB_STALL_COUNT_EN
        ,
        .Stall_Count(Stall_Count)
`endif
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [63:0] waiting[$];      // first-word packets awaiting their immediate
    logic [15:0] m_instr = 16'h0;
    logic [31:0] m_imm   = 32'h0;
    logic [31:0] m_pc    = 32'h0;
    logic [15:0] m_side  = 16'h0;
    logic        m_valid = 1'b0;
    int          m_count = 0;
    bit          model_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        waiting.delete();
        m_instr = 16'h0000; m_imm = 32'h0; m_pc = 32'h0; m_side = 16'h0; m_valid = 1'b0;
        m_count = 0;
    endtask

    // Apply the packet-level rules for one rising edge with the current inputs.
    task automatic model_edge();
        logic [63:0] p;
        if (Rst) begin
            model_reset();
            return;
        end
        if (Stall && !Flush && m_count < 65535) m_count++;
        if (Flush) begin
            waiting.delete();
            m_instr = 16'h0000; m_imm = 32'h0; m_pc = 32'h0; m_side = 16'h0; m_valid = 1'b0;
        end else if (!Stall) begin
            if (waiting.size() != 0) begin
                p = waiting.pop_front();
                m_instr = p[15:0]; m_pc = p[47:16]; m_side = p[63:48];
                m_imm = {16'h0, In[15:0]}; m_valid = 1'b1;
            end else if (In[15]) begin
                waiting.push_back(In);
                m_instr = 16'h0000; m_imm = 32'h0; m_pc = 32'h0; m_side = 16'h0; m_valid = 1'b0;
            end else begin
                m_instr = In[15:0]; m_pc = In[47:16]; m_side = In[63:48];
                m_imm = 32'h0; m_valid = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic step(input logic [63:0] pkt, input logic st, input logic fl);
        In = pkt; Stall = st; Flush = fl;
        @(posedge Clk);
        model_edge();
        #1;
        $display("cycle in=%h stall=%0b flush=%0b -> instr=%h imm=%h pc=%h side=%h valid=%0b hold=%0b",
                 pkt, st, fl, Out_Instr, Out_Imm, Out_PC, Out_Side, Out_Valid, Fetch_Hold);
    endtask

    // Single compare process: every cycle, against the model.
    always @(negedge Clk) begin
        if (model_on) begin
            chk("valid", {63'h0, Out_Valid}, {63'h0, m_valid});
            chk("instr", {48'h0, Out_Instr}, {48'h0, m_instr});
            chk("fetch_hold", {63'h0, Fetch_Hold}, {63'h0, (waiting.size() != 0)});
            if (m_valid) begin
                chk("imm", {32'h0, Out_Imm}, {32'h0, m_imm});
                chk("pc", {32'h0, Out_PC}, {32'h0, m_pc});
                chk("side", {48'h0, Out_Side}, {48'h0, m_side});
            end
`ifdef FDB_STALL_COUNT_EN
            chk("stall_count", {48'h0, Stall_Count}, 64'(m_count));
`endif
        end
    end

    initial begin
        // Power-on reset
        model_reset();
        model_on = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_valid", {63'h0, Out_Valid}, 64'h0);
        chk("rst_instr", {48'h0, Out_Instr}, 64'h0);
        chk("rst_pc", {32'h0, Out_PC}, 64'h0);
        Rst = 1'b0;

        // One-word instruction
        step({16'hABCD, 32'h00000011, 16'h1234}, 0, 0);
        chk("w1_instr", {48'h0, Out_Instr}, 64'h1234);
        chk("w1_pc", {32'h0, Out_PC}, 64'h11);
        chk("w1_side", {48'h0, Out_Side}, 64'hABCD);
        chk("w1_imm", {32'h0, Out_Imm}, 64'h0);
        chk("w1_valid", {63'h0, Out_Valid}, 64'h1);

        // Two-word instruction
        step({16'h1111, 32'h00000020, 16'h8005}, 0, 0);
        chk("w2a_valid", {63'h0, Out_Valid}, 64'h0);
        chk("w2a_hold", {63'h0, Fetch_Hold}, 64'h1);
        step({16'h2222, 32'h00000021, 16'hBEEF}, 0, 0);
        chk("w2_instr", {48'h0, Out_Instr}, 64'h8005);
        chk("w2_imm", {32'h0, Out_Imm}, 64'h0000BEEF);
        chk("w2_pc", {32'h0, Out_PC}, 64'h20);
        chk("w2_side", {48'h0, Out_Side}, 64'h1111);
        chk("w2_valid", {63'h0, Out_Valid}, 64'h1);
        chk("w2_hold", {63'h0, Fetch_Hold}, 64'h0);

        // Stall while waiting for the immediate
        step({16'h3333, 32'h00000030, 16'h8001}, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step({16'h4444, 32'h00000031 + 32'(i), 16'h9000 + 16'(i)}, 1, 0);
            chk("stall_hold", {63'h0, Fetch_Hold}, 64'h1);
            chk("stall_valid", {63'h0, Out_Valid}, 64'h0);
        end
        step({16'h5555, 32'h00000035, 16'h0042}, 0, 0);
        chk("stall_imm", {32'h0, Out_Imm}, 64'h42);
        chk("stall_instr", {48'h0, Out_Instr}, 64'h8001);
        chk("stall_pc", {32'h0, Out_PC}, 64'h30);

        // Flush together with stall in the immediate-wait state
        step({16'h6666, 32'h00000040, 16'h8003}, 0, 0);
        step({16'h7777, 32'h00000041, 16'hCAFE}, 1, 1);
        chk("flush_valid", {63'h0, Out_Valid}, 64'h0);
        chk("flush_instr", {48'h0, Out_Instr}, 64'h0);
        chk("flush_hold", {63'h0, Fetch_Hold}, 64'h0);
        chk("flush_pc", {32'h0, Out_PC}, 64'h0);
        chk("flush_side", {48'h0, Out_Side}, 64'h0);
        step({16'h8888, 32'h00000042, 16'h0007}, 0, 0);
        chk("post_flush_instr", {48'h0, Out_Instr}, 64'h7);
        chk("post_flush_valid", {63'h0, Out_Valid}, 64'h1);

        // Back-to-back two-word instructions, then a one-word one
        step({16'h0A0A, 32'h00000050, 16'h8010}, 0, 0);
        step({16'h0B0B, 32'h00000051, 16'hAAAA}, 0, 0);
        step({16'h0C0C, 32'h00000052, 16'h8020}, 0, 0);
        step({16'h0D0D, 32'h00000053, 16'hBBBB}, 0, 0);
        chk("b2b_imm", {32'h0, Out_Imm}, 64'hBBBB);
        chk("b2b_pc", {32'h0, Out_PC}, 64'h52);
        step({16'h0E0E, 32'h00000054, 16'h0030}, 0, 0);
        chk("b2b_next", {48'h0, Out_Instr}, 64'h30);

        // Stall with a valid output holds it; flush from the first-word state
        step({16'h0F0F, 32'h00000060, 16'h0055}, 0, 0);
        step({16'h1010, 32'h00000061, 16'h0066}, 1, 0);
        step({16'h1111, 32'h00000062, 16'h0077}, 1, 0);
        chk("stall_first_instr", {48'h0, Out_Instr}, 64'h55);
        chk("stall_first_pc", {32'h0, Out_PC}, 64'h60);
        step({16'h1212, 32'h00000063, 16'h0088}, 0, 1);
        chk("flush_first_valid", {63'h0, Out_Valid}, 64'h0);

        // Asynchronous reset while waiting for an immediate
        step({16'h1313, 32'h00000070, 16'h8099}, 0, 0);
        #2;
        Rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", {63'h0, Out_Valid}, 64'h0);
        chk("arst_instr", {48'h0, Out_Instr}, 64'h0);
        chk("arst_pc", {32'h0, Out_PC}, 64'h0);
        chk("arst_hold", {63'h0, Fetch_Hold}, 64'h0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        step({16'h1414, 32'h00000080, 16'h0123}, 0, 0);
        chk("after_arst", {48'h0, Out_Instr}, 64'h0123);

`ifdef FDB_STALL_COUNT_EN
        // Stall counter: fresh from reset, 5 stalls then a flush+stall cycle
        Rst = 1'b1;
        model_reset();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        for (int i = 0; i < 5; i++) step(64'h0, 1, 0);
        step(64'h0, 1, 1);
        chk("count_5", {48'h0, Stall_Count}, 64'd5);
        for (int i = 0; i < 65540; i++) begin
            In = 64'h0; Stall = 1'b1; Flush = 1'b0;
            @(posedge Clk);
            model_edge();
            #1;
        end
        chk("count_sat", {48'h0, Stall_Count}, 64'hFFFF);
        step(64'h0, 0, 1);
        chk("count_flush_keep", {48'h0, Stall_Count}, 64'hFFFF);
`endif

        step(64'h0, 0, 0);
        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
